// File: rtl/fill_check.sv
// Reads a BRAM image back over AXI4 in 256-byte INCR bursts and checks every
// 32-bit word against its expected index pattern, counting errored beats.
module fill_check #(
    parameter int          IW        = 2,
    parameter int          AW        = 20,
    parameter int          DW        = 512,
    parameter logic [31:0] BRAM_SIZE = 32'h1000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [IW-1:0] M_AXI_ARID,
    output logic          M_AXI_ARLOCK,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic          M_AXI_RVALID,
    input  logic          M_AXI_RLAST,
    input  logic [1:0]    M_AXI_RRESP,
    output logic          M_AXI_RREADY
);

    localparam int          BYTES        = DW / 8;
    localparam int          BEATS        = 256 / BYTES;
    localparam int          LANES        = DW / 32;
    localparam logic [31:0] TOTAL_BURSTS = BRAM_SIZE / 32'd256;
    localparam logic [7:0]  LAST_BEAT    = 8'(BEATS - 1);
    localparam logic [31:0] BYTES_W      = 32'(BYTES);
    localparam logic [31:0] LANES_W      = 32'(LANES);

    typedef enum logic {AR_IDLE = 1'b0, AR_ISSUE = 1'b1} ar_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RUN = 1'b1} r_state_t;

    ar_state_t     ar_state_r, ar_state_s;
    r_state_t      r_state_r, r_state_s;
    logic [AW-1:0] araddr_r;
    logic [31:0]   ar_issued_r;
    logic [2:0]    outstanding_r, outst_next_s;
    logic [7:0]    beat_in_burst_r;
    logic [31:0]   bursts_done_r;
    logic [31:0]   beat_idx_r;
    logic [31:0]   err_count_r, err_next_s;
    logic [AW-1:0] first_err_addr_r;
    logic          done_r, pass_r;
    logic          start_acc_s, ar_hs_s, beat_s, burst_end_s, final_beat_s, beat_err_s;

    function automatic logic lane_mismatch(input logic [DW-1:0] data, input logic [31:0] n);
        logic        bad;
        logic [31:0] base;
        bad  = 1'b0;
        base = n * LANES_W;
        for (int k = 0; k < LANES; k++) begin
            if (data[32*k +: 32] != base + 32'(k)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign start_acc_s  = start && (r_state_r == R_IDLE);
    assign ar_hs_s      = (ar_state_r == AR_ISSUE) && M_AXI_ARREADY;
    assign beat_s       = (r_state_r == R_RUN) && M_AXI_RVALID;
    assign burst_end_s  = beat_s && (beat_in_burst_r == LAST_BEAT);
    assign final_beat_s = burst_end_s && (bursts_done_r == TOTAL_BURSTS - 32'd1);
    assign beat_err_s   = lane_mismatch(M_AXI_RDATA, beat_idx_r) || (M_AXI_RRESP != 2'b00)
                        || (M_AXI_RLAST != (beat_in_burst_r == LAST_BEAT));

    // Outstanding-burst bookkeeping and saturating error count for this cycle
    always_comb begin
        outst_next_s = outstanding_r;
        err_next_s   = err_count_r;
        case ({ar_hs_s, burst_end_s})
            2'b10:   outst_next_s = outstanding_r + 3'd1;
            2'b01:   outst_next_s = outstanding_r - 3'd1;
            default: outst_next_s = outstanding_r;
        endcase
        if (beat_s && beat_err_s && (err_count_r != 32'hFFFF_FFFF)) begin
            err_next_s = err_count_r + 32'd1;
        end else begin
            err_next_s = err_count_r;
        end
    end

    // AR next state: a request once raised is held until accepted
    always_comb begin
        ar_state_s = ar_state_r;
        case (ar_state_r)
            AR_IDLE: begin
                if ((r_state_r == R_RUN) && (ar_issued_r < TOTAL_BURSTS) && (outstanding_r < 3'd4)) begin
                    ar_state_s = AR_ISSUE;
                end else begin
                    ar_state_s = AR_IDLE;
                end
            end
            AR_ISSUE: begin
                if (ar_hs_s && ((ar_issued_r == TOTAL_BURSTS - 32'd1) || (outst_next_s == 3'd4))) begin
                    ar_state_s = AR_IDLE;
                end else begin
                    ar_state_s = AR_ISSUE;
                end
            end
            default: ar_state_s = AR_IDLE;
        endcase
    end

    // R next state: runs from accepted start to the last beat of the last burst
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (start_acc_s) begin
                    r_state_s = R_RUN;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_RUN: begin
                if (final_beat_s) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_RUN;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_r <= AR_IDLE;
            r_state_r  <= R_IDLE;
        end else begin
            ar_state_r <= ar_state_s;
            r_state_r  <= r_state_s;
        end
    end

    // Address generation, beat tracking and result registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr_r         <= '0;
            ar_issued_r      <= 32'd0;
            outstanding_r    <= 3'd0;
            beat_in_burst_r  <= 8'd0;
            bursts_done_r    <= 32'd0;
            beat_idx_r       <= 32'd0;
            err_count_r      <= 32'd0;
            first_err_addr_r <= '0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
        end else if (start_acc_s) begin
            araddr_r         <= '0;
            ar_issued_r      <= 32'd0;
            outstanding_r    <= 3'd0;
            beat_in_burst_r  <= 8'd0;
            bursts_done_r    <= 32'd0;
            beat_idx_r       <= 32'd0;
            err_count_r      <= 32'd0;
            first_err_addr_r <= '0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
        end else begin
            outstanding_r <= outst_next_s;
            err_count_r   <= err_next_s;
            if (ar_hs_s) begin
                araddr_r    <= araddr_r + AW'(32'd256);
                ar_issued_r <= ar_issued_r + 32'd1;
            end
            if (beat_s) begin
                beat_idx_r      <= beat_idx_r + 32'd1;
                beat_in_burst_r <= burst_end_s ? 8'd0 : beat_in_burst_r + 8'd1;
                if (burst_end_s) begin
                    bursts_done_r <= bursts_done_r + 32'd1;
                end
                // Saturated count is never zero again, so zero means no error yet
                if (beat_err_s && (err_count_r == 32'd0)) begin
                    first_err_addr_r <= AW'(beat_idx_r * BYTES_W);
                end
            end
            if (final_beat_s) begin
                done_r <= 1'b1;
                pass_r <= (err_next_s == 32'd0);
            end
        end
    end

    assign busy           = (r_state_r == R_RUN);
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_addr_r;
    assign M_AXI_ARADDR   = araddr_r;
    assign M_AXI_ARVALID  = (ar_state_r == AR_ISSUE);
    assign M_AXI_RREADY   = (r_state_r == R_RUN);
    assign M_AXI_ARLEN    = LAST_BEAT;
    assign M_AXI_ARSIZE   = 3'($clog2(BYTES));
    assign M_AXI_ARBURST  = 2'b01;
    assign M_AXI_ARID     = '0;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = 4'd0;
    assign M_AXI_ARQOS    = 4'd0;
    assign M_AXI_ARPROT   = 3'd0;

endmodule

// File: tb/tb_fill_check.sv
// Directed bench for fill_check: behavioural AXI read slave serving the index
// pattern with optional corruption, plus scenario tasks with inline checks.
module tb_fill_check;

    logic          clk = 1'b0;
    logic          resetn, start, busy, done, pass;
    logic [31:0]   err_count;
    logic [19:0]   first_err_addr, araddr;
    logic          arvalid, arready, arlock;
    logic [7:0]    arlen;
    logic [2:0]    arsize, arprot;
    logic [1:0]    arburst, arid, rresp;
    logic [3:0]    arcache, arqos;
    logic [511:0]  rdata;
    logic          rvalid, rlast, rready;

    int checks = 0;
    int errors = 0;

    // slave controls (written by the main process at negedge)
    logic r_en;
    int   corrupt_beat, corrupt_lane, rresp_beat, rlast_beat;
    logic [31:0] corrupt_val;

    // slave bookkeeping
    int ar_log[$];
    int pend[$];
    int bpos, ar_hs_cnt, beat_cnt, beats_at_5th;

    always #5 clk = ~clk;

    fill_check dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARID(arid),
        .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos), .M_AXI_ARPROT(arprot),
        .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RLAST(rlast), .M_AXI_RRESP(rresp),
        .M_AXI_RREADY(rready)
    );

    // AXI read slave: samples just before the edge, updates just after it
    initial begin : slave
        logic ar_hs, r_hs;
        int   a, n;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        bpos = 0; ar_hs_cnt = 0; beat_cnt = 0; beats_at_5th = 0;
        forever begin
            @(negedge clk); #4;
            ar_hs = arvalid && arready;
            a     = int'(araddr);
            r_hs  = rvalid && rready;
            @(posedge clk); #1;
            if (!resetn) begin
                pend.delete();
                bpos = 0;
            end else begin
                if (ar_hs) begin
                    ar_log.push_back(a);
                    pend.push_back(a);
                    ar_hs_cnt++;
                    if (ar_hs_cnt == 5) beats_at_5th = beat_cnt;
                end
                if (r_hs) begin
                    beat_cnt++;
                    bpos++;
                    if (bpos == 4) begin
                        void'(pend.pop_front());
                        bpos = 0;
                    end
                end
            end
            if (resetn && r_en && pend.size() > 0) begin
                n = pend[0] / 64 + bpos;
                rvalid = 1'b1;
                for (int k = 0; k < 16; k++) rdata[32*k +: 32] = 32'(n * 16 + k);
                if (n == corrupt_beat) rdata[32*corrupt_lane +: 32] = corrupt_val;
                rresp = (n == rresp_beat) ? 2'b10 : 2'b00;
                rlast = (bpos == 3) || (n == rlast_beat);
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
    end

    task automatic clear_faults();
        corrupt_beat = -1; corrupt_lane = 0; corrupt_val = 32'd0;
        rresp_beat = -1; rlast_beat = -1;
        ar_log.delete();
        ar_hs_cnt = 0; beat_cnt = 0; beats_at_5th = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, c);
        end
    endtask

    task automatic check_result(input string name, input logic exp_pass, input int exp_err,
                                input int exp_first, input int exp_ars);
        checks++;
        if (pass !== exp_pass) begin errors++; $display("FAIL %s_pass: got %0b want %0b", name, pass, exp_pass); end
        checks++;
        if (err_count !== 32'(exp_err)) begin errors++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, exp_err); end
        checks++;
        if (first_err_addr !== 20'(exp_first)) begin errors++; $display("FAIL %s_first_err_addr: got %0h want %0h", name, first_err_addr, exp_first); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %0b want 0", name, busy); end
        checks++;
        if (ar_hs_cnt != exp_ars) begin errors++; $display("FAIL %s_ar_count: got %0d want %0d", name, ar_hs_cnt, exp_ars); end
        checks++;
        if (beat_cnt != exp_ars * 4) begin errors++; $display("FAIL %s_beat_count: got %0d want %0d", name, beat_cnt, exp_ars * 4); end
        for (int i = 0; i < ar_log.size(); i++) begin
            checks++;
            if (ar_log[i] != i * 256) begin errors++; $display("FAIL %s_araddr[%0d]: got %0h want %0h", name, i, ar_log[i], i * 256); end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, pass, arvalid, rready} !== 5'b0) begin
            errors++;
            $display("FAIL %s_flags: busy/done/pass/arvalid/rready got %b want 00000", name, {busy, done, pass, arvalid, rready});
        end
        checks++;
        if (err_count !== 32'd0 || first_err_addr !== 20'd0 || araddr !== 20'd0) begin
            errors++;
            $display("FAIL %s_values: err=%0d first=%0h araddr=%0h want 0/0/0", name, err_count, first_err_addr, araddr);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; arready = 1'b1; r_en = 1'b1;
        clear_faults();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        checks++;
        if (arlen !== 8'd3 || arsize !== 3'd6 || arburst !== 2'b01 || arid !== 2'd0 ||
            arlock !== 1'b0 || arcache !== 4'd0 || arqos !== 4'd0 || arprot !== 3'd0) begin
            errors++;
            $display("FAIL reset_ar_consts: len=%0d size=%0d burst=%0d id=%0d want 3/6/1/0", arlen, arsize, arburst, arid);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        clear_faults();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL clean_started: busy=%0b done=%0b want 1/0", busy, done); end
        wait_done("clean");
        check_result("clean", 1'b1, 0, 0, 16);
    endtask

    task automatic test_corrupt_word();
        clear_faults();
        corrupt_beat = 16; corrupt_lane = 1; corrupt_val = 32'hDEAD;
        pulse_start();
        checks++;
        if (done !== 1'b0 || err_count !== 32'd0) begin errors++; $display("FAIL corrupt_cleared: done=%0b err=%0d want 0/0", done, err_count); end
        wait_done("corrupt");
        check_result("corrupt", 1'b0, 1, 32'h400, 16);
    endtask

    task automatic test_outstanding_cap();
        clear_faults();
        r_en = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        checks++;
        if (ar_hs_cnt != 4) begin errors++; $display("FAIL cap_ar_count: got %0d want 4", ar_hs_cnt); end
        checks++;
        if (arvalid !== 1'b0) begin errors++; $display("FAIL cap_arvalid: got %0b want 0", arvalid); end
        r_en = 1'b1;
        wait_done("cap");
        checks++;
        if (beats_at_5th < 4) begin errors++; $display("FAIL cap_fifth_ar: beats before 5th AR got %0d want >=4", beats_at_5th); end
        check_result("cap", 1'b1, 0, 0, 16);
    endtask

    task automatic test_protocol_errors();
        clear_faults();
        rresp_beat = 5; rlast_beat = 13;
        pulse_start();
        wait_done("proto");
        check_result("proto", 1'b0, 2, 32'h140, 16);
    endtask

    task automatic test_reset_mid_pass();
        int c;
        clear_faults();
        corrupt_beat = 3; corrupt_lane = 0; corrupt_val = 32'h5A5A;
        pulse_start();
        c = 0;
        while (beat_cnt < 32 && c < 2000) begin @(negedge clk); c++; end
        checks++;
        if (beat_cnt < 32) begin errors++; $display("FAIL midreset_progress: beats %0d want 32", beat_cnt); end
        checks++;
        if (err_count !== 32'd1) begin errors++; $display("FAIL midreset_pre_err: got %0d want 1", err_count); end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        resetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset_after");
        clear_faults();
        pulse_start();
        wait_done("midreset_rerun");
        check_result("midreset_rerun", 1'b1, 0, 0, 16);
    endtask

    task automatic test_back_to_back();
        clear_faults();
        corrupt_beat = 40; corrupt_lane = 15; corrupt_val = 32'h0;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (17) @(negedge clk);
        pulse_start();
        wait_done("b2b");
        check_result("b2b", 1'b0, 1, 40 * 64, 16);
        // start right after done begins a fresh pass and clears done
        clear_faults();
        pulse_start();
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: done=%0b pass=%0b busy=%0b want 0/0/1", done, pass, busy);
        end
        wait_done("b2b_second");
        check_result("b2b_second", 1'b1, 0, 0, 16);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_corrupt_word();
        test_outstanding_cap();
        test_protocol_errors();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
